// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO port arbiters: FSM state encoding and
// a width helper for counters and pointers.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_rr_sel.sv
// Combinational round-robin picker: first set request at or after the
// pointer, modulo N, returned one-hot with a hit flag.
module fifo_rr_sel
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_sel,
    output logic          o_hit
);

    always_comb begin
        int idx;
        idx   = 0;
        o_sel = '0;
        o_hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(i_ptr) + k) % N;
            if (!o_hit && i_req[idx]) begin
                o_sel[idx] = 1'b1;
                o_hit      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_fwft_rd_arbiter.sv
// Round-robin, burst-limited sharing of one FWFT FIFO read port.
// Optional idle-grant timeout enabled by defining FIFO_RD_ARB_TIMEOUT_EN.
module fifo_fwft_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_PORTS = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     fifo_din,
    output logic                 fifo_rden,
    input  logic                 fifo_empty,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] rden_i,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] valid,
    output logic [WIDTH-1:0]     dout,
    output logic                 timeout_o
);

    localparam int PW = clog2(NUM_PORTS);
    localparam int CW = clog2(MAX_BURST + 1);
    localparam int BL = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(BL);
    localparam logic [PW-1:0] LAST_PORT  = PW'(NUM_PORTS - 1);

    arb_state_t           r_state;
    logic [NUM_PORTS-1:0] r_grant;
    logic [PW-1:0]        r_gidx;
    logic [PW-1:0]        r_ptr;
    logic [CW-1:0]        r_bcnt;

    logic                 w_pop;
    logic                 w_burst_done;
    logic                 w_drop;
    logic                 w_to;
    logic                 w_release;
    logic [PW-1:0]        w_ptr_nxt;
    logic [PW-1:0]        w_sel_ptr;
    logic [NUM_PORTS-1:0] w_sel;
    logic                 w_hit;
    logic [PW-1:0]        w_sel_idx;

    // Pops are suppressed outright while reset is held.
    assign w_pop     = |(r_grant & rden_i) & !fifo_empty & !rst;
    assign fifo_rden = w_pop;
    assign valid     = fifo_empty ? '0 : r_grant;
    assign dout      = fifo_din;
    assign grant     = r_grant;

    assign w_burst_done = (MAX_BURST != 0) && w_pop && (r_bcnt == BURST_LAST);
    assign w_drop       = (r_state == BUSY) && !req[r_gidx];
    assign w_release    = (r_state == BUSY) && (w_burst_done || w_drop || w_to);
    assign w_ptr_nxt    = (r_gidx == LAST_PORT) ? '0 : r_gidx + 1'b1;
    assign w_sel_ptr    = (r_state == BUSY) ? w_ptr_nxt : r_ptr;

    fifo_rr_sel #(
        .N  (NUM_PORTS),
        .PW (PW)
    ) u_sel (
        .i_req (req),
        .i_ptr (w_sel_ptr),
        .o_sel (w_sel),
        .o_hit (w_hit)
    );

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_sel[i]) w_sel_idx = PW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_bcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_state <= BUSY;
                        r_grant <= w_sel;
                        r_gidx  <= w_sel_idx;
                        r_bcnt  <= '0;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        // Handoff in the same edge; the old holder may be re-granted.
                        r_ptr  <= w_ptr_nxt;
                        r_bcnt <= '0;
                        if (w_hit) begin
                            r_grant <= w_sel;
                            r_gidx  <= w_sel_idx;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= '0;
                        end
                    end else if (w_pop) begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_RD_ARB_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [TW-1:0] r_tcnt;
    logic          r_to;
    logic          w_idle;

    // Idle means data is waiting but the holder is not taking it.
    assign w_idle    = (r_state == BUSY) && !fifo_empty && !w_pop;
    assign w_to      = w_idle && (r_tcnt == TO_LAST);
    assign timeout_o = r_to;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
            r_to   <= 1'b0;
        end else begin
            r_to <= w_to;
            if ((r_state == IDLE) || w_release || w_pop) begin
                r_tcnt <= '0;
            end else if (w_idle) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end
`else
    assign w_to      = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_fwft_rd_arbiter.sv
// Directed bench for fifo_fwft_rd_arbiter with a behavioural FWFT FIFO.
module tb_fifo_fwft_rd_arbiter;

    localparam int WIDTH = 8;
    localparam int NP    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] fifo_din;
    logic             fifo_rden;
    logic             fifo_empty;
    logic [NP-1:0]    req;
    logic [NP-1:0]    rden_i;
    logic [NP-1:0]    grant;
    logic [NP-1:0]    valid;
    logic [WIDTH-1:0] dout;
    logic             timeout_o;

    logic [7:0]  mem [256];
    logic [15:0] rd_ptr = '0;
    logic [15:0] wr_ptr = '0;
    int          pops = 0;
    int          pops_port [NP] = '{0, 0, 0, 0};
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    fifo_fwft_rd_arbiter #(
        .WIDTH     (WIDTH),
        .NUM_PORTS (NP),
        .MAX_BURST (16),
        .TIMEOUT   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_din   (fifo_din),
        .fifo_rden  (fifo_rden),
        .fifo_empty (fifo_empty),
        .req        (req),
        .rden_i     (rden_i),
        .grant      (grant),
        .valid      (valid),
        .dout       (dout),
        .timeout_o  (timeout_o)
    );

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_din   = mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (fifo_rden) begin
            rd_ptr <= rd_ptr + 16'd1;
            pops   <= pops + 1;
            for (int i = 0; i < NP; i++) begin
                if (grant[i]) pops_port[i] <= pops_port[i] + 1;
            end
        end
    end

    task automatic push(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = base + 8'(i);
            wr_ptr = wr_ptr + 16'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        req    = '0;
        rden_i = '0;
        wr_ptr = rd_ptr;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst    = 1'b1;
        req    = 4'b1111;
        rden_i = 4'b1111;
        push(3, 8'h10);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        total++;
        if (fifo_rden !== 1'b0) begin bad++; $display("FAIL reset_rden got=%b exp=0", fifo_rden); end
        total++;
        if (valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", valid); end
        total++;
        if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
        total++;
        if (pops !== 0) begin bad++; $display("FAIL reset_pops got=%0d exp=0", pops); end
        req    = '0;
        rden_i = '0;
        wr_ptr = rd_ptr;
        rst    = 1'b0;
    endtask

    task automatic test_single();
        int p0;
        do_reset();
        push(3, 8'hA0);
        req    = 4'b0001;
        rden_i = 4'b0001;
        p0     = pops;
        #1;
        total++;
        if (grant !== 4'b0000) begin bad++; $display("FAIL single_latency got=%b exp=0000", grant); end
        @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", grant); end
        total++;
        if (dout !== 8'hA0) begin bad++; $display("FAIL single_dout got=%h exp=a0", dout); end
        total++;
        if (fifo_rden !== 1'b1) begin bad++; $display("FAIL single_rden got=%b exp=1", fifo_rden); end
        repeat (4) @(negedge clk);
        total++;
        if (pops - p0 !== 3) begin bad++; $display("FAIL single_pops got=%0d exp=3", pops - p0); end
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL single_hold got=%b exp=0001", grant); end
        total++;
        if (valid !== 4'b0000) begin bad++; $display("FAIL single_valid_empty got=%b exp=0000", valid); end
        req    = '0;
        rden_i = '0;
        @(negedge clk);
        total++;
        if (grant !== 4'b0000) begin bad++; $display("FAIL single_release got=%b exp=0000", grant); end
    endtask

    task automatic test_back_to_back();
        int pp [NP];
        logic [NP-1:0] exp_g;
        do_reset();
        for (int i = 0; i < NP; i++) pp[i] = pops_port[i];
        push(64, 8'h00);
        req    = 4'b1111;
        rden_i = 4'b1111;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            exp_g = 4'b0001 << ((k - 1) / 16);
            total++;
            if (grant !== exp_g) begin bad++; $display("FAIL b2b_grant k=%0d got=%b exp=%b", k, grant, exp_g); end
            total++;
            if (fifo_rden !== 1'b1) begin bad++; $display("FAIL b2b_gap k=%0d got=%b exp=1", k, fifo_rden); end
            total++;
            if (dout !== 8'(k - 1)) begin bad++; $display("FAIL b2b_dout k=%0d got=%h exp=%h", k, dout, 8'(k - 1)); end
        end
        @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL b2b_wrap got=%b exp=0001", grant); end
        for (int i = 0; i < NP; i++) begin
            total++;
            if (pops_port[i] - pp[i] !== 16) begin
                bad++; $display("FAIL b2b_count port=%0d got=%0d exp=16", i, pops_port[i] - pp[i]);
            end
        end
        req    = '0;
        rden_i = '0;
    endtask

    task automatic test_drop();
        int p1;
        do_reset();
        push(20, 8'h40);
        p1     = pops_port[1];
        req    = 4'b1010;
        rden_i = 4'b0010;
        @(negedge clk);
        total++;
        if (grant !== 4'b0010) begin bad++; $display("FAIL drop_first got=%b exp=0010", grant); end
        repeat (4) @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        total++;
        if (pops_port[1] - p1 !== 5) begin bad++; $display("FAIL drop_pops got=%0d exp=5", pops_port[1] - p1); end
        total++;
        if (grant !== 4'b1000) begin bad++; $display("FAIL drop_handoff got=%b exp=1000", grant); end
        req    = '0;
        rden_i = '0;
    endtask

    task automatic test_ignored();
        int p0;
        do_reset();
        push(4, 8'h70);
        req    = 4'b0001;
        rden_i = 4'b0100;
        p0     = pops;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (fifo_rden !== 1'b0) begin bad++; $display("FAIL ign_other k=%0d got=%b exp=0", k, fifo_rden); end
        end
        total++;
        if (valid !== 4'b0001) begin bad++; $display("FAIL ign_valid got=%b exp=0001", valid); end
        wr_ptr = rd_ptr;
        rden_i = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (fifo_rden !== 1'b0) begin bad++; $display("FAIL ign_empty k=%0d got=%b exp=0", k, fifo_rden); end
            @(negedge clk);
        end
        total++;
        if (pops - p0 !== 0) begin bad++; $display("FAIL ign_pops got=%0d exp=0", pops - p0); end
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL ign_hold got=%b exp=0001", grant); end
        req    = '0;
        rden_i = '0;
    endtask

    task automatic test_reset_mid();
        int p0;
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        total++;
        if (grant !== 4'b0000) begin bad++; $display("FAIL rmid_idle got=%b exp=0000", grant); end
        push(20, 8'h90);
        req    = 4'b0010;
        rden_i = 4'b0010;
        p0     = pops;
        @(negedge clk);
        total++;
        if (grant !== 4'b0010) begin bad++; $display("FAIL rmid_grant got=%b exp=0010", grant); end
        repeat (7) @(negedge clk);
        total++;
        if (pops - p0 !== 7) begin bad++; $display("FAIL rmid_pops got=%0d exp=7", pops - p0); end
        rst    = 1'b1;
        req    = 4'b1111;
        rden_i = 4'b1111;
        #1;
        total++;
        if (fifo_rden !== 1'b0) begin bad++; $display("FAIL rmid_rden got=%b exp=0", fifo_rden); end
        @(negedge clk);
        total++;
        if (grant !== 4'b0000) begin bad++; $display("FAIL rmid_clear got=%b exp=0000", grant); end
        total++;
        if (pops - p0 !== 7) begin bad++; $display("FAIL rmid_nopop got=%0d exp=7", pops - p0); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL rmid_port0 got=%b exp=0001", grant); end
        req    = '0;
        rden_i = '0;
    endtask

`ifdef FIFO_RD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int pulses;
        do_reset();
        push(4, 8'hC0);
        req    = 4'b0100;
        rden_i = 4'b0000;
        pulses = 0;
        @(negedge clk);
        total++;
        if (grant !== 4'b0100) begin bad++; $display("FAIL to_grant got=%b exp=0100", grant); end
        req = 4'b0101;
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            if (timeout_o === 1'b1) pulses++;
            if (k == 8) begin
                total++;
                if (grant !== 4'b0100) begin bad++; $display("FAIL to_early got=%b exp=0100", grant); end
            end
            if (k == 9) begin
                total++;
                if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b exp=1", timeout_o); end
                total++;
                if (grant !== 4'b0001) begin bad++; $display("FAIL to_handoff got=%b exp=0001", grant); end
            end
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
        req = '0;
    endtask
`else
    task automatic test_timeout();
        int pulses;
        do_reset();
        push(4, 8'hC0);
        req    = 4'b0101;
        rden_i = 4'b0000;
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (timeout_o !== 1'b0) pulses++;
        end
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL nto_hold got=%b exp=0001", grant); end
        total++;
        if (valid !== 4'b0001) begin bad++; $display("FAIL nto_valid got=%b exp=0001", valid); end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL nto_pulses got=%0d exp=0", pulses); end
        req = '0;
    endtask
`endif

    initial begin
        rst    = 1'b1;
        req    = '0;
        rden_i = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_ignored();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_fwft_rd_arbiter.md
Name: fifo_fwft_rd_arbiter

Overview:
Shares the read port of one first-word-fall-through (FWFT) FIFO among NUM_PORTS consumers.
- Grants are round-robin.
- Each grant is held for a burst of up to MAX_BURST words, or until the consumer drops its request.
- Sits between a FIFO (fifo_din/fifo_rden/fifo_empty) and several consumers, each seeing its own FWFT-style valid/rden pair.

Parameters:
WIDTH, 8, data width in bits.
NUM_PORTS, 4, number of consumers (>=1).
MAX_BURST, 16, maximum pops per grant; 0 = unlimited.
TIMEOUT, 256, idle-grant cycles before forced release (used only with the optional feature).

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
fifo_din  input  WIDTH  FWFT head word from FIFO.
fifo_rden  output  1  pop strobe to FIFO.
fifo_empty  input  1  FIFO empty flag.
req  input  NUM_PORTS  per-consumer request.
rden_i  input  NUM_PORTS  per-consumer pop request.
grant  output  NUM_PORTS  one-hot registered grant.
valid  output  NUM_PORTS  head word valid for that consumer.
dout  output  WIDTH  broadcast data, equals fifo_din.
timeout_o  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset values:
  - grant=0, state=IDLE, burst count=0, rr pointer=0 (port 0 highest priority first), timeout_o=0.
  - fifo_rden=0 while rst is high, regardless of other inputs.
- States:
  - IDLE: no grant. If any req bit is set, the registered grant goes to the first requester at or after the rr pointer, modulo NUM_PORTS. Enter BUSY. Latency req->grant = 1 cycle.
  - BUSY: grant[g]=1.
- Combinational outputs, not registered:
  - valid[g] = !fifo_empty.
  - valid[i≠g] = 0.
  - fifo_rden = grant[g] & rden_i[g] & !fifo_empty.
  - dout = fifo_din.
- Ignored pops: rden_i from non-granted ports, and rden_i while empty, never cause a pop.
- Burst counting:
  - The counter increments on every fifo_rden.
  - The grant releases at the clock edge of the MAX_BURST-th pop.
- Release on request drop:
  - The grant also releases when req[g]=0 is sampled.
  - A pop in that same cycle is still honoured.
- Release and handoff:
  - On release, the rr pointer becomes g+1 (wrapping).
  - The next grant is selected in the same cycle from the pointer onward, excluding nothing. If g is the only requester, g is re-granted; its burst counter clears.
  - The grant changes with no dead cycle (back-to-back handoff). If no requests remain, go to IDLE.
- Grant held on an empty FIFO: the grant persists and does not count toward the burst.
- MAX_BURST=0: release only on req drop (or timeout).
- NUM_PORTS=1: degenerates to gating by req; the same rules apply.
- Reset mid-burst: the grant clears on that edge, the counter clears, and no pop occurs in the reset cycle.
- Simultaneous req assertion by several ports in IDLE: the lowest index at or after the pointer wins.

Optional Feature:
FIFO_RD_ARB_TIMEOUT_EN
- Defined:
  - A per-grant idle counter counts cycles with grant held, fifo_empty=0 and no pop.
  - It resets on each pop or new grant.
  - On reaching TIMEOUT, the grant is forcibly released (same handoff rules) and timeout_o pulses high for 1 cycle.
- Undefined: no idle counter; timeout_o tied 0; the grant is held indefinitely.

Decomposition:
- Shared package fifo_arb_pkg:
  - state encodings IDLE/BUSY;
  - a clog2 function for counter and pointer widths.
- One natural sub-module, fifo_rr_sel: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot select, any-hit flag.
  - Reusable by a future write-side arbiter.

Test Plan:
- Reset then req=4'b0001, FIFO holding 3 words, rden_i[0]=1 continuously -> grant=0001 one cycle after req; 3 pops; then valid[0]=0 while grant is held.
- req=4'b1111, MAX_BURST=16, FIFO full of 64 words, all rden_i=1 -> grants 0001,0010,0100,1000 in order; exactly 16 pops each; back-to-back handoff with no gap cycle.
- Ports 1 and 3 requesting, port 1 drops req after 5 pops -> grant moves to port 3 on the next edge; the pop in the drop cycle is counted; the rr pointer becomes 2.
- rden_i[2]=1 while grant=0001, and rden_i[0]=1 while fifo_empty=1 -> fifo_rden stays 0 throughout.
- rst asserted mid-burst (after 7 pops) -> grant=0 and no pop in the reset cycle; after release, port 0 wins first.
- With FIFO_RD_ARB_TIMEOUT_EN, TIMEOUT=8, grant to port 2, data present, rden_i=0 -> after 8 cycles timeout_o pulses once and the grant passes to the next requester.
